// File: rtl/seq_gen_pkg.sv
// Shared types and default widths for the seq_gen serial pattern generator.
package seq_gen_pkg;

   localparam int unsigned DEF_PATTERN_W  = 8;
   localparam int unsigned DEF_LEN_W      = 4;
   localparam int unsigned DEF_REP_W      = 4;
   localparam int unsigned DEF_GAP_CYCLES = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam state_e RESET_STATE = IDLE;

endpackage

// File: rtl/seq_gen_cnt.sv
// Loadable saturating down-counter; used for bit index, repetition and gap counts.
module seq_gen_cnt #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] value_o,
   output logic             is_one_c_o,
   output logic             is_zero_c_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Load wins over decrement; decrement stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value_o     = cnt_q;
   assign is_one_c_o  = (cnt_q == WIDTH'(1));
   assign is_zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/seq_gen.sv
// Bit-serial pattern generator: shifts a latched pattern out MSB-first, repeated reps times.
// Define SEQ_GEN_GAP_EN to insert GAP_CYCLES idle cycles between repetitions.
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int unsigned PATTERN_W  = DEF_PATTERN_W,
   parameter int unsigned LEN_W      = DEF_LEN_W,
   parameter int unsigned REP_W      = DEF_REP_W,
   parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [PATTERN_W-1:0] pattern,
   input  logic [LEN_W-1:0]     len,
   input  logic [REP_W-1:0]     reps,
   output logic                 x,
   output logic                 x_valid,
   output logic                 busy,
   output logic                 done
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PATTERN_W);

   if (((1 << LEN_W) <= PATTERN_W) || (GAP_CYCLES > 1024)) begin : g_bad_params
      $error("seq_gen: LEN_W too narrow for PATTERN_W or GAP_CYCLES out of range");
   end

   function automatic logic bit_at(input logic [PATTERN_W-1:0] p, input logic [LEN_W-1:0] i);
      logic [PATTERN_W-1:0] s;
      s = p >> i;
      return s[0];
   endfunction

   state_e                state_q, state_d;
   logic [PATTERN_W-1:0]  pattern_q;
   logic [LEN_W-1:0]      len_m1_q;
   logic                  x_q, x_valid_q, busy_q, done_q;
   logic                  x_d, x_valid_d, busy_d, done_d;
   logic                  start_ok, lat_en;
   logic                  idx_load, idx_dec, idx_zero, idx_one;
   logic [LEN_W-1:0]      idx_load_val, idx_val, idx_next;
   logic                  rep_load, rep_dec, rep_one, rep_zero;
   logic [REP_W-1:0]      rep_val;
   logic                  unused_cnt;

   assign start_ok = start && (len != '0) && (reps != '0) && (len <= MAX_LEN)
                     && ((state_q == IDLE) || (state_q == DONE));

   seq_gen_cnt #(.WIDTH(LEN_W)) u_idx_cnt (
      .clk_i       (clk),
      .rst_i       (rst),
      .load_i      (idx_load),
      .load_val_i  (idx_load_val),
      .dec_i       (idx_dec),
      .value_o     (idx_val),
      .is_one_c_o  (idx_one),
      .is_zero_c_o (idx_zero)
   );

   seq_gen_cnt #(.WIDTH(REP_W)) u_rep_cnt (
      .clk_i       (clk),
      .rst_i       (rst),
      .load_i      (rep_load),
      .load_val_i  (reps),
      .dec_i       (rep_dec),
      .value_o     (rep_val),
      .is_one_c_o  (rep_one),
      .is_zero_c_o (rep_zero)
   );

   assign unused_cnt = ^{idx_one, rep_val};

`ifdef SEQ_GEN_GAP_EN
   localparam bit          GAP_ON   = (GAP_CYCLES != 0);
   localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   logic             gap_load, gap_dec, gap_zero, gap_one;
   logic [GAP_W-1:0] gap_val;
   logic             unused_gap;

   seq_gen_cnt #(.WIDTH(GAP_W)) u_gap_cnt (
      .clk_i       (clk),
      .rst_i       (rst),
      .load_i      (gap_load),
      .load_val_i  (GAP_W'(GAP_LOAD)),
      .dec_i       (gap_dec),
      .value_o     (gap_val),
      .is_one_c_o  (gap_one),
      .is_zero_c_o (gap_zero)
   );

   assign unused_gap = ^{gap_val, gap_one};
`endif

   // State, latched job and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RESET_STATE;
         pattern_q <= '0;
         len_m1_q  <= '0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         if (lat_en) begin
            pattern_q <= pattern;
            len_m1_q  <= len - LEN_W'(1);
         end
      end
   end

   // Next state and counter control.
   always_comb begin
      state_d      = state_q;
      lat_en       = 1'b0;
      idx_load     = 1'b0;
      idx_dec      = 1'b0;
      idx_load_val = len_m1_q;
      rep_load     = 1'b0;
      rep_dec      = 1'b0;
`ifdef SEQ_GEN_GAP_EN
      gap_load     = 1'b0;
      gap_dec      = 1'b0;
`endif
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start_ok) begin
               state_d      = SHIFT;
               lat_en       = 1'b1;
               idx_load     = 1'b1;
               idx_load_val = len - LEN_W'(1);
               rep_load     = 1'b1;
            end
         end
         SHIFT: begin
            if (!idx_zero) begin
               idx_dec = 1'b1;
            end else if (rep_one || rep_zero) begin
               state_d = DONE;
            end else begin
               rep_dec = 1'b1;
`ifdef SEQ_GEN_GAP_EN
               if (GAP_ON) begin
                  state_d  = GAP;
                  gap_load = 1'b1;
               end else begin
                  idx_load = 1'b1;
               end
`else
               idx_load = 1'b1;
`endif
            end
         end
`ifdef SEQ_GEN_GAP_EN
         GAP: begin
            if (gap_zero) begin
               state_d  = SHIFT;
               idx_load = 1'b1;
            end else begin
               gap_dec = 1'b1;
            end
         end
`endif
         default: state_d = RESET_STATE;
      endcase
   end

   // Output values for the coming cycle, derived from the next state and next bit index.
   always_comb begin
      x_d       = 1'b0;
      x_valid_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      idx_next  = idx_val;
      if (idx_load) begin
         idx_next = idx_load_val;
      end else if (idx_dec) begin
         idx_next = idx_val - LEN_W'(1);
      end
      case (state_d)
         SHIFT: begin
            x_d       = bit_at(lat_en ? pattern : pattern_q, idx_next);
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
         end
         GAP:     busy_d = 1'b1;
         DONE:    done_d = 1'b1;
         default: ;
      endcase
   end

   assign x       = x_q;
   assign x_valid = x_valid_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: vector table, corner-case sequences and a random run against a stream model.
module tb_seq_gen;

   localparam int unsigned PW = 8;
   localparam int unsigned LW = 4;
   localparam int unsigned RW = 4;
`ifdef SEQ_GEN_GAP_EN
   localparam int unsigned GAP_C = 2;
`else
   localparam int unsigned GAP_C = 0;
`endif

   logic          clk = 1'b0;
   logic          rst, start;
   logic [PW-1:0] pattern;
   logic [LW-1:0] len;
   logic [RW-1:0] reps;
   logic          x, x_valid, busy, done;

   always #5 clk = ~clk;

   seq_gen #(.PATTERN_W(PW), .LEN_W(LW), .REP_W(RW), .GAP_CYCLES(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .pattern (pattern),
      .len     (len),
      .reps    (reps),
      .x       (x),
      .x_valid (x_valid),
      .busy    (busy),
      .done    (done)
   );

   int total = 0;
   int bad   = 0;

   // Model: expected output stream {x, x_valid, busy, done}, one entry per cycle.
   logic [3:0] exp_q[$];
   logic [3:0] cur = 4'b0000;

   function automatic logic [3:0] obs();
      return {x, x_valid, busy, done};
   endfunction

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got x/v/busy/done=%b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic s, input logic [PW-1:0] p,
                             input logic [LW-1:0] l, input logic [RW-1:0] n);
      if (r) begin
         exp_q.delete();
         cur = 4'b0000;
         return;
      end
      if (s && (l != 0) && (n != 0) && (int'(l) <= int'(PW)) && !cur[1]) begin
         exp_q.delete();
         for (int k = 0; k < int'(n); k++) begin
            for (int b = int'(l) - 1; b >= 0; b--) exp_q.push_back({p[b], 3'b110});
            if (k < int'(n) - 1)
               for (int g = 0; g < int'(GAP_C); g++) exp_q.push_back(4'b0010);
         end
         exp_q.push_back(4'b0001);
      end
      cur = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
   endtask

   // Drive one cycle of inputs, advance the model at the edge, compare at the falling edge.
   task automatic step(input logic r, input logic s, input logic [PW-1:0] p,
                       input logic [LW-1:0] l, input logic [RW-1:0] n);
      rst = r; start = s; pattern = p; len = l; reps = n;
      @(posedge clk);
      model_edge(r, s, p, l, n);
      @(negedge clk);
      chk("model", obs(), cur);
   endtask

   typedef struct {
      logic          r;
      logic          s;
      logic [PW-1:0] p;
      logic [LW-1:0] l;
      logic [RW-1:0] n;
      logic [3:0]    e;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int            busy_cnt, valid_cnt, done_cnt, done_at;
      logic [8:0]    bits;
      logic [PW-1:0] a5;
      logic          seen;

      rst = 1'b1; start = 1'b0; pattern = '0; len = '0; reps = '0;
      @(negedge clk);
      step(1'b1, 1'b0, '0, '0, '0);
      chk("reset", obs(), 4'b0000);

      tbl[0]  = '{1'b0, 1'b1, 8'h0B, 4'd4,  4'd1, 4'b1110};
      tbl[1]  = '{1'b0, 1'b0, 8'hFF, 4'd2,  4'd2, 4'b0110};
      tbl[2]  = '{1'b0, 1'b1, 8'hFF, 4'd2,  4'd2, 4'b1110};
      tbl[3]  = '{1'b0, 1'b0, 8'h00, 4'd0,  4'd0, 4'b1110};
      tbl[4]  = '{1'b0, 1'b0, 8'h00, 4'd0,  4'd0, 4'b0001};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 4'd0,  4'd0, 4'b0000};
      tbl[6]  = '{1'b0, 1'b1, 8'hFF, 4'd0,  4'd1, 4'b0000};
      tbl[7]  = '{1'b0, 1'b1, 8'hFF, 4'd0,  4'd1, 4'b0000};
      tbl[8]  = '{1'b0, 1'b1, 8'hFF, 4'd3,  4'd0, 4'b0000};
      tbl[9]  = '{1'b0, 1'b1, 8'hFF, 4'd9,  4'd1, 4'b0000};
      tbl[10] = '{1'b0, 1'b1, 8'hFF, 4'd15, 4'd3, 4'b0000};
      tbl[11] = '{1'b0, 1'b0, 8'h00, 4'd0,  4'd0, 4'b0000};
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].l, tbl[i].n);
         chk($sformatf("tbl%0d", i), obs(), tbl[i].e);
      end

      // 3-bit pattern repeated three times.
      busy_cnt = 0; valid_cnt = 0; done_cnt = 0; done_at = 0; bits = '0;
      step(1'b0, 1'b1, 8'h05, 4'd3, 4'd3);
      for (int c = 1; c <= 20; c++) begin
         if (busy) busy_cnt++;
         if (x_valid) begin bits = {bits[7:0], x}; valid_cnt++; end
         if (done) begin done_cnt++; done_at = c; end
         step(1'b0, 1'b0, 8'hFF, 4'd1, 4'd1);
      end
      chk("rep_busy_cycles", 4'(busy_cnt), 4'(9 + 2 * GAP_C));
      chk("rep_done_at", 4'(done_at), 4'(10 + 2 * GAP_C));
      chk("rep_done_count", 4'(done_cnt), 4'd1);
      chk("rep_valid_count", 4'(valid_cnt), 4'd9);
      chk("rep_bits_hi", bits[8:5], 4'b1011);
      chk("rep_bits_lo", {1'b0, bits[4:2]}, 4'b0011);
      chk("rep_bits_tail", {2'b00, bits[1:0]}, 4'b0001);

      // Reset while the third bit is on the line.
      step(1'b0, 1'b1, 8'hC3, 4'd8, 4'd2);
      step(1'b0, 1'b0, 8'h00, 4'd0, 4'd0);
      step(1'b0, 1'b0, 8'h00, 4'd0, 4'd0);
      step(1'b1, 1'b0, 8'h00, 4'd0, 4'd0);
      chk("rst_abort", obs(), 4'b0000);
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step(1'b0, 1'b0, 8'h00, 4'd0, 4'd0);
         if (done || busy || x_valid) seen = 1'b1;
      end
      chk("rst_no_done", {3'b000, seen}, 4'b0000);
      step(1'b0, 1'b1, 8'h96, 4'd8, 4'd1);
      for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 8'h00, 4'd0, 4'd0);

      // Start accepted in the DONE cycle; start pulses while busy are ignored.
      step(1'b0, 1'b1, 8'h0D, 4'd4, 4'd1);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (done) seen = 1'b1;
         else step(1'b0, 1'b0, 8'h00, 4'd0, 4'd0);
      end
      chk("done_seen", {3'b000, seen}, 4'b0001);
      a5 = 8'hA5;
      step(1'b0, 1'b1, a5, 4'd8, 4'd1);
      for (int b = 7; b >= 0; b--) begin
         chk($sformatf("a5_bit%0d", b), obs(), {a5[b], 3'b110});
         if (b == 5) step(1'b0, 1'b1, 8'hFF, 4'd2, 4'd1);
         else step(1'b0, 1'b0, 8'h00, 4'd0, 4'd0);
      end
      chk("a5_done", obs(), 4'b0001);

      // Random traffic against the stream model.
      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(0, 59) == 0),
              ($urandom_range(0, 2) == 0),
              PW'($urandom),
              LW'($urandom_range(0, 10)),
              RW'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
